// File: rtl/seller_pkg.sv
// Shared coin encodings, price limits and transaction states for the ticket seller.
package seller_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_1    = 2'b01;
   localparam logic [1:0] COIN_5    = 2'b10;
   localparam logic [1:0] COIN_10   = 2'b11;

   localparam logic [3:0] PRICE_MIN = 4'd2;
   localparam logic [3:0] PRICE_MAX = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_ISSUE,
      S_PAYOUT
   } txn_state_t;

   function automatic logic [7:0] coin_value(input logic [1:0] coin);
      logic [7:0] v;
      case (coin)
         COIN_1:  v = 8'd1;
         COIN_5:  v = 8'd5;
         COIN_10: v = 8'd10;
         default: v = 8'd0;
      endcase
      return v;
   endfunction

   function automatic logic price_legal(input logic [3:0] price);
      return (price >= PRICE_MIN) && (price <= PRICE_MAX);
   endfunction

   // Largest denomination not exceeding the amount still owed.
   function automatic logic [1:0] greedy_coin(input logic [7:0] amount);
      logic [1:0] c;
      if (amount >= 8'd10)     c = COIN_10;
      else if (amount >= 8'd5) c = COIN_5;
      else if (amount != 8'd0) c = COIN_1;
      else                     c = COIN_NONE;
      return c;
   endfunction

endpackage

// File: rtl/ticket_txn_ctrl_if.sv
// Front-panel, coin-acceptor, printer and hopper signals of the ticket controller.
interface ticket_txn_ctrl_if;

   logic       sel_valid;
   logic [3:0] sel_price;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       confirm;
   logic       cancel;
   logic       disp_ready;

   logic       ticket_valid;
   logic [3:0] ticket_type;
   logic       coin_out_valid;
   logic [1:0] coin_out_type;
   logic       coin_reject;
   logic       sel_err;
   logic       short_err;
   logic [7:0] credit;
   logic       busy;

   modport master (
      output sel_valid, sel_price, coin_valid, coin_type, confirm, cancel, disp_ready,
      input  ticket_valid, ticket_type, coin_out_valid, coin_out_type,
             coin_reject, sel_err, short_err, credit, busy
   );

   modport slave (
      input  sel_valid, sel_price, coin_valid, coin_type, confirm, cancel, disp_ready,
      output ticket_valid, ticket_type, coin_out_valid, coin_out_type,
             coin_reject, sel_err, short_err, credit, busy
   );

endinterface

// File: rtl/change_dispenser.sv
// Greedy 10/5/1 change selector with a registered hopper offer.
// Latency: coin offered the cycle after the owner's next-credit becomes nonzero while active.
// Backpressure: offer held stable while disp_ready is low; next coin follows an accept with no bubble.
module change_dispenser
   import seller_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] credit,
   input  logic       active,
   input  logic       disp_ready,
   output logic       coin_out_valid,
   output logic [1:0] coin_out_type,
   output logic [7:0] dec_amount
);

   logic hold;

   assign hold       = coin_out_valid && !disp_ready;
   assign dec_amount = (coin_out_valid && disp_ready) ? coin_value(coin_out_type) : 8'd0;

   // credit is the owner's post-handshake value, so a reload picks the next denomination.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coin_out_valid <= 1'b0;
         coin_out_type  <= COIN_NONE;
      end else if (!active || (credit == 8'd0)) begin
         coin_out_valid <= 1'b0;
         coin_out_type  <= COIN_NONE;
      end else if (!hold) begin
         coin_out_valid <= 1'b1;
         coin_out_type  <= greedy_coin(credit);
      end
   end

endmodule

// File: rtl/ticket_txn_ctrl.sv
// Ticket transaction FSM: select, collect credit, issue, then pay change or refund.
// Latency: all outputs registered, one cycle after the causing strobe; confirm N -> ticket N+1.
// Backpressure: payout stalls indefinitely on disp_ready low; coins offered in other states are rejected.
module ticket_txn_ctrl
   import seller_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input logic              clk,
   input logic              rst_n,
   ticket_txn_ctrl_if.slave txn
);

   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYC);

   txn_state_t  state, state_nxt;
   logic [7:0]  credit_q, credit_nxt;
   logic [3:0]  price, price_nxt;
   logic [15:0] tmo_cnt, tmo_cnt_nxt;

   logic        ticket_valid_q, ticket_valid_nxt;
   logic [3:0]  ticket_type_q, ticket_type_nxt;
   logic        coin_reject_q, coin_reject_nxt;
   logic        sel_err_q, sel_err_nxt;
   logic        short_err_q, short_err_nxt;
   logic        busy_q;

   logic        coin_in, strobe, sel_legal, disp_active;
   logic [8:0]  coin_sum;
   logic [7:0]  dec_amount;

   assign coin_in   = txn.coin_valid && (txn.coin_type != COIN_NONE);
   assign strobe    = txn.sel_valid || txn.coin_valid || txn.confirm || txn.cancel;
   assign sel_legal = price_legal(txn.sel_price);
   assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value(txn.coin_type)};

   // Cancel/timeout entries wait one PAYOUT cycle before the first offer; ISSUE preloads it.
   assign disp_active = ((state == S_ISSUE) || (state == S_PAYOUT)) && (state_nxt == S_PAYOUT);

   always_comb begin
      state_nxt        = state;
      credit_nxt       = credit_q;
      price_nxt        = price;
      tmo_cnt_nxt      = '0;
      ticket_valid_nxt = 1'b0;
      ticket_type_nxt  = '0;
      coin_reject_nxt  = 1'b0;
      sel_err_nxt      = 1'b0;
      short_err_nxt    = 1'b0;

      case (state)
         S_IDLE: begin
            if (txn.sel_valid) begin
               if (sel_legal) begin
                  price_nxt = txn.sel_price;
                  state_nxt = S_COLLECT;
               end else begin
                  sel_err_nxt = 1'b1;
               end
            end
            if (coin_in) coin_reject_nxt = 1'b1;
         end

         S_COLLECT: begin
            if (coin_in) begin
               if (coin_sum[8]) coin_reject_nxt = 1'b1;
               else             credit_nxt      = coin_sum[7:0];
            end
            if (txn.sel_valid) begin
               if (sel_legal) price_nxt   = txn.sel_price;
               else           sel_err_nxt = 1'b1;
            end
            if (txn.cancel) begin
               state_nxt = S_PAYOUT;
            end else if (txn.confirm) begin
               if (credit_nxt >= {4'd0, price}) begin
                  state_nxt        = S_ISSUE;
                  ticket_valid_nxt = 1'b1;
                  ticket_type_nxt  = price;
               end else begin
                  short_err_nxt = 1'b1;
               end
            end
            if (!strobe) begin
               if (tmo_cnt == TMO_LIMIT) state_nxt   = S_PAYOUT;
               else                      tmo_cnt_nxt = tmo_cnt + 16'd1;
            end
         end

         S_ISSUE: begin
            credit_nxt = credit_q - {4'd0, price};
            if (coin_in) coin_reject_nxt = 1'b1;
            if (credit_nxt != 8'd0) begin
               state_nxt = S_PAYOUT;
            end else begin
               state_nxt = S_IDLE;
               price_nxt = '0;
            end
         end

         S_PAYOUT: begin
            credit_nxt = credit_q - dec_amount;
            if (coin_in) coin_reject_nxt = 1'b1;
            if (credit_nxt == 8'd0) begin
               state_nxt = S_IDLE;
               price_nxt = '0;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         credit_q       <= '0;
         price          <= '0;
         tmo_cnt        <= '0;
         ticket_valid_q <= 1'b0;
         ticket_type_q  <= '0;
         coin_reject_q  <= 1'b0;
         sel_err_q      <= 1'b0;
         short_err_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state          <= state_nxt;
         credit_q       <= credit_nxt;
         price          <= price_nxt;
         tmo_cnt        <= tmo_cnt_nxt;
         ticket_valid_q <= ticket_valid_nxt;
         ticket_type_q  <= ticket_type_nxt;
         coin_reject_q  <= coin_reject_nxt;
         sel_err_q      <= sel_err_nxt;
         short_err_q    <= short_err_nxt;
         busy_q         <= (state_nxt != S_IDLE);
      end
   end

   change_dispenser u_disp (
      .clk            (clk),
      .rst_n          (rst_n),
      .credit         (credit_nxt),
      .active         (disp_active),
      .disp_ready     (txn.disp_ready),
      .coin_out_valid (txn.coin_out_valid),
      .coin_out_type  (txn.coin_out_type),
      .dec_amount     (dec_amount)
   );

   assign txn.ticket_valid = ticket_valid_q;
   assign txn.ticket_type  = ticket_type_q;
   assign txn.coin_reject  = coin_reject_q;
   assign txn.sel_err      = sel_err_q;
   assign txn.short_err    = short_err_q;
   assign txn.credit       = credit_q;
   assign txn.busy         = busy_q;

endmodule

// File: tb/tb_ticket_txn_ctrl.sv
// Scoreboard bench: a transaction-level model predicts every output cycle; a monitor compares.
module tb_ticket_txn_ctrl;

   localparam int TMO = 8;
   localparam int C1 = 1, C5 = 2, C10 = 3;
   localparam int M_IDLE = 0, M_COLL = 1, M_ISSUE = 2, M_PAY = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ticket_txn_ctrl_if bus ();

   ticket_txn_ctrl #(.TIMEOUT_CYC(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .txn   (bus)
   );

   typedef struct {
      int cyc;
      int tv;
      int tt;
      int cov;
      int cot;
      int rej;
      int serr;
      int sherr;
      int cr;
      int busy;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;

   int   m_mode, m_credit, m_price, m_idle, m_wait;
   int   m_coins[$];

   int   obs_coin_q[$];
   int   tk_q[$];

   bit   rdy_rand = 1'b0;
   bit   rdy_fix = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cval(input logic [1:0] t);
      case (t)
         2'b01:   return 1;
         2'b10:   return 5;
         2'b11:   return 10;
         default: return 0;
      endcase
   endfunction

   function automatic void chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endfunction

   function automatic int qsum();
      int s = 0;
      foreach (obs_coin_q[i]) s += obs_coin_q[i];
      return s;
   endfunction

   function automatic void model_reset();
      m_mode = M_IDLE; m_credit = 0; m_price = 0; m_idle = 0; m_wait = 0;
      m_coins.delete();
   endfunction

   // Refund/change as a list of greedy denominations, paid one per accepted handshake.
   function automatic void start_payout(input int amt, input int wait_cycles);
      int a = amt;
      m_coins.delete();
      while (a >= 10) begin m_coins.push_back(10); a -= 10; end
      while (a >= 5)  begin m_coins.push_back(5);  a -= 5;  end
      while (a >= 1)  begin m_coins.push_back(1);  a -= 1;  end
      m_mode = M_PAY;
      m_wait = wait_cycles;
   endfunction

   function automatic void model_step(input int sv, input int sp, input int cv, input int ct,
                                      input int cf, input int cn, input int dr);
      exp_t e;
      int coin   = (cv != 0) ? cval(ct[1:0]) : 0;
      int strobe = ((sv | cv | cf | cn) != 0) ? 1 : 0;
      int p0     = m_price;
      int legal  = (sp >= 2 && sp <= 10) ? 1 : 0;
      e.cyc = cyc + 1; e.tv = 0; e.tt = 0; e.cov = 0; e.cot = 0;
      e.rej = 0; e.serr = 0; e.sherr = 0; e.cr = 0; e.busy = 0;
      case (m_mode)
         M_IDLE: begin
            if (sv != 0) begin
               if (legal != 0) begin m_price = sp; m_mode = M_COLL; m_idle = 0; end
               else e.serr = 1;
            end
            if (coin > 0) e.rej = 1;
         end
         M_COLL: begin
            if (coin > 0) begin
               if (m_credit + coin > 255) e.rej = 1;
               else m_credit += coin;
            end
            if (sv != 0) begin
               if (legal != 0) m_price = sp;
               else e.serr = 1;
            end
            if (cn != 0) start_payout(m_credit, 1);
            else if (cf != 0) begin
               if (m_credit >= p0) begin e.tv = 1; e.tt = p0; m_mode = M_ISSUE; end
               else e.sherr = 1;
            end
            if (strobe == 0) begin
               if (m_idle == TMO) start_payout(m_credit, 1);
               else m_idle++;
            end else m_idle = 0;
         end
         M_ISSUE: begin
            if (coin > 0) e.rej = 1;
            m_credit -= m_price;
            if (m_credit > 0) start_payout(m_credit, 0);
            else begin m_mode = M_IDLE; m_price = 0; end
         end
         default: begin
            if (coin > 0) e.rej = 1;
            if (m_coins.size() == 0) begin m_mode = M_IDLE; m_price = 0; end
            else if (m_wait > 0) m_wait--;
            else if (dr != 0) begin
               m_credit -= m_coins.pop_front();
               if (m_coins.size() == 0) begin m_mode = M_IDLE; m_price = 0; end
            end
         end
      endcase
      e.cov  = (m_mode == M_PAY && m_wait == 0 && m_coins.size() > 0) ? 1 : 0;
      e.cot  = (e.cov != 0) ? m_coins[0] : 0;
      e.cr   = m_credit;
      e.busy = (m_mode != M_IDLE) ? 1 : 0;
      exp_q.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.ticket_valid) tk_q.push_back(int'(bus.ticket_type));
         if (bus.coin_out_valid && bus.disp_ready) obs_coin_q.push_back(cval(bus.coin_out_type));
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            chk("stale_expectation", mon_e.cyc, cyc);
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            chk("ticket_valid", int'(bus.ticket_valid), mon_e.tv);
            chk("ticket_type", int'(bus.ticket_type), mon_e.tt);
            chk("coin_out_valid", int'(bus.coin_out_valid), mon_e.cov);
            if (mon_e.cov != 0) chk("coin_out_type", cval(bus.coin_out_type), mon_e.cot);
            chk("coin_reject", int'(bus.coin_reject), mon_e.rej);
            chk("sel_err", int'(bus.sel_err), mon_e.serr);
            chk("short_err", int'(bus.short_err), mon_e.sherr);
            chk("credit", int'(bus.credit), mon_e.cr);
            chk("busy", int'(bus.busy), mon_e.busy);
         end
      end
   end

   task automatic step(input int sv, input int sp, input int cv, input int ct,
                       input int cf, input int cn);
      int dr;
      dr = rdy_rand ? (($urandom_range(0, 3) != 0) ? 1 : 0) : int'(rdy_fix);
      bus.sel_valid  = sv[0];
      bus.sel_price  = sp[3:0];
      bus.coin_valid = cv[0];
      bus.coin_type  = ct[1:0];
      bus.confirm    = cf[0];
      bus.cancel     = cn[0];
      bus.disp_ready = dr[0];
      model_step(sv, sp, cv, ct, cf, cn, dr);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();          step(0, 0, 0, 0, 0, 0); endtask
   task automatic sel(input int p); step(1, p, 0, 0, 0, 0); endtask
   task automatic coin(input int t); step(0, 0, 1, t, 0, 0); endtask
   task automatic conf();          step(0, 0, 0, 0, 1, 0); endtask
   task automatic canc();          step(0, 0, 0, 0, 0, 1); endtask

   task automatic drain(input string name);
      int n = 0;
      while (m_mode != M_IDLE && n < 400) begin idle(); n++; end
      if (m_mode != M_IDLE) chk({name, "_drain_timeout"}, n, 0);
   endtask

   task automatic clear_obs();
      obs_coin_q.delete();
      tk_q.delete();
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_ticket_valid"}, int'(bus.ticket_valid), 0);
      chk({name, "_ticket_type"}, int'(bus.ticket_type), 0);
      chk({name, "_coin_out_valid"}, int'(bus.coin_out_valid), 0);
      chk({name, "_coin_out_type"}, int'(bus.coin_out_type), 0);
      chk({name, "_coin_reject"}, int'(bus.coin_reject), 0);
      chk({name, "_sel_err"}, int'(bus.sel_err), 0);
      chk({name, "_short_err"}, int'(bus.short_err), 0);
      chk({name, "_credit"}, int'(bus.credit), 0);
      chk({name, "_busy"}, int'(bus.busy), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.sel_valid = 0; bus.sel_price = 0; bus.coin_valid = 0; bus.coin_type = 0;
      bus.confirm = 0; bus.cancel = 0; bus.disp_ready = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Exact payment.
      rdy_fix = 1; clear_obs();
      sel(7); coin(C5); coin(C1); coin(C1); conf(); drain("exact");
      chk("exact_tickets", tk_q.size(), 1);
      chk("exact_type", tk_q[0], 7);
      chk("exact_no_change", obs_coin_q.size(), 0);
      chk("exact_credit", int'(bus.credit), 0);

      // Change with a four-cycle hopper stall after the first coin.
      clear_obs();
      sel(3); coin(C10); coin(C10); conf(); idle(); idle();
      rdy_fix = 0;
      for (int i = 0; i < 4; i++) begin
         chk("stall_valid", int'(bus.coin_out_valid), 1);
         chk("stall_type", cval(bus.coin_out_type), 5);
         idle();
      end
      rdy_fix = 1; drain("change");
      chk("change_ticket", tk_q[0], 3);
      chk("change_count", obs_coin_q.size(), 4);
      chk("change_0", obs_coin_q[0], 10);
      chk("change_1", obs_coin_q[1], 5);
      chk("change_2", obs_coin_q[2], 1);
      chk("change_3", obs_coin_q[3], 1);

      // Short confirm, then cancel.
      clear_obs();
      sel(9); coin(C5); conf();
      chk("short_err_pulse", int'(bus.short_err), 1);
      canc(); drain("short");
      chk("short_refund_n", obs_coin_q.size(), 1);
      chk("short_refund_v", qsum(), 5);
      chk("short_no_ticket", tk_q.size(), 0);

      // Illegal inputs.
      sel(11);
      chk("illegal_sel_err", int'(bus.sel_err), 1);
      chk("illegal_busy", int'(bus.busy), 0);
      coin(C5);
      chk("idle_coin_reject", int'(bus.coin_reject), 1);
      clear_obs();
      sel(2); coin(C10); rdy_fix = 0; canc();
      step(0, 0, 1, C5, 0, 0);
      chk("payout_coin_reject", int'(bus.coin_reject), 1);
      chk("payout_credit_kept", int'(bus.credit), 10);
      rdy_fix = 1; drain("payout_reject");
      chk("payout_refund_v", qsum(), 10);

      // Same-cycle coin with cancel, and coin with confirm.
      clear_obs();
      sel(5); step(0, 0, 1, C10, 0, 1); drain("coin_cancel");
      chk("coin_cancel_refund", qsum(), 10);
      clear_obs();
      sel(5); step(0, 0, 1, C5, 1, 0); drain("coin_confirm");
      chk("coin_confirm_ticket", tk_q[0], 5);
      chk("coin_confirm_no_change", obs_coin_q.size(), 0);

      // Credit overflow.
      clear_obs();
      sel(10);
      for (int i = 0; i < 25; i++) coin(C10);
      coin(C10);
      chk("overflow_reject", int'(bus.coin_reject), 1);
      chk("overflow_credit", int'(bus.credit), 250);
      canc(); drain("overflow");
      chk("overflow_refund_n", obs_coin_q.size(), 25);
      chk("overflow_refund_v", qsum(), 250);

      // Inactivity timeout.
      clear_obs();
      sel(4); coin(C1); drain("timeout");
      chk("timeout_refund_n", obs_coin_q.size(), 1);
      chk("timeout_refund_v", qsum(), 1);

      // Reset in the middle of a stalled payout.
      sel(2); coin(C10); coin(C10); rdy_fix = 0; canc(); idle(); idle(); idle();
      chk("pre_reset_offer", int'(bus.coin_out_valid), 1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("midpay_reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rdy_fix = 1;
      sel(6); coin(C10); conf(); drain("post_reset");

      // Randomized traffic.
      rdy_rand = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         int op, sp, ct;
         op = $urandom_range(0, 99);
         sp = $urandom_range(0, 15);
         ct = $urandom_range(1, 3);
         if (op < 30)      idle();
         else if (op < 40) sel(sp);
         else if (op < 65) coin(ct);
         else if (op < 75) conf();
         else if (op < 80) canc();
         else if (op < 88) step(0, 0, 1, ct, 1, 0);
         else if (op < 94) step(0, 0, 1, ct, 0, 1);
         else              step(0, 0, 0, 0, 1, 1);
      end
      drain("random");
      idle();
      @(negedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ticket_txn_ctrl.md
# ticket_txn_ctrl

Sequential transaction controller for the self-service ticket machine. It latches a ticket selection, accumulates coin credit one event per cycle, and issues the ticket on confirm. It then pays out change, or refunds on cancel or timeout, through a one-coin-per-handshake dispenser interface using greedy 10/5/1 denominations. It sits between the front-panel/coin-acceptor logic and the ticket printer and coin hopper.

## Interface
- `TIMEOUT_CYC`, default 1000: cycles of inactivity in COLLECT before auto-refund; 16-bit counter, legal range 1..65535.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `sel_valid` in 1: one-cycle selection strobe.
- `sel_price` in 4: requested ticket price; legal range 2..10.
- `coin_valid` in 1: one-cycle coin-inserted strobe.
- `coin_type` in 2: inserted coin; 01 = 1, 10 = 5, 11 = 10; 00 is ignored.
- `confirm` in 1: purchase strobe.
- `cancel` in 1: abort strobe.
- `disp_ready` in 1: hopper accepts a coin this cycle.
- `ticket_valid` out 1: one-cycle ticket-issue pulse.
- `ticket_type` out 4: price of the issued ticket; holds 0 except while `ticket_valid` is high.
- `coin_out_valid` out 1: change/refund coin offered to the hopper.
- `coin_out_type` out 2: denomination of the offered coin, same encoding as `coin_type`.
- `coin_reject` out 1: one-cycle pulse; the inserted coin is returned unaccepted.
- `sel_err` out 1: one-cycle pulse; illegal price was selected.
- `short_err` out 1: one-cycle pulse; confirm arrived with insufficient credit.
- `credit` out 8: current accumulated credit.
- `busy` out 1: high in every state except IDLE.

## Operation
- States are IDLE, COLLECT, ISSUE, PAYOUT.
- **IDLE**
  - A `sel_valid` with a legal price latches `price` and moves to COLLECT.
  - An illegal price pulses `sel_err` and stays in IDLE.
  - A coin arriving in IDLE pulses `coin_reject`.
- **COLLECT**
  - A coin adds 1, 5 or 10 to `credit`. If the sum would exceed 255, `coin_reject` pulses and `credit` is unchanged.
  - A legal `sel_valid` re-latches `price`. An illegal one pulses `sel_err` and keeps the old price.
  - `confirm` compares `credit_next` (including a coin arriving in the same cycle) against `price`.
    - If `credit_next >= price`: go to ISSUE.
    - Otherwise: pulse `short_err` and stay in COLLECT.
  - `cancel` goes to PAYOUT with the full credit. `cancel` beats `confirm` in the same cycle; a same-cycle coin is still credited first.
  - The inactivity counter resets on any strobe. Reaching `TIMEOUT_CYC` goes to PAYOUT.
- **ISSUE** (exactly 1 cycle)
  - Drives `ticket_valid` = 1 and `ticket_type` = `price`.
  - `credit` <= `credit - price`.
  - Next state is PAYOUT if the remaining credit is nonzero, otherwise IDLE.
- **PAYOUT**
  - Offers the largest coin with value <= `credit`: 10, else 5, else 1.
  - On `coin_out_valid && disp_ready`, `credit` drops by the coin value.
  - When `credit` reaches 0, go to IDLE and clear `price`.
  - Inputs `coin_valid` arriving in PAYOUT get `coin_reject`. `confirm`, `cancel` and `sel_valid` are ignored.
- **Arithmetic**
  - `credit` is an 8-bit unsigned value.
  - The subtraction never underflows, because ISSUE is entered only when credit >= price.

## Timing
- **Reset values**
  - State IDLE; `credit` = 0, `price` = 0, timeout counter = 0.
  - All outputs are 0.
  - Reset mid-PAYOUT abandons the remaining change; this is accepted by system policy.
- **Outputs**
  - All outputs are registered.
  - Pulses occur in the cycle after the causing strobe.
- **Confirm to ticket**
  - `confirm` at cycle N gives `ticket_valid` at N+1.
  - The first change coin is offered at N+2.
- **Hopper handshake**
  - `coin_out_valid` and `coin_out_type` are held stable until a cycle with `disp_ready` = 1.
  - The next coin is offered the cycle after each accepted handshake, with no bubble, so the maximum rate is 1 coin per cycle.
  - `disp_ready` low stalls indefinitely; there is no timeout in PAYOUT.
- **Timeout and cancel**
  - Timeout fires on the cycle the counter equals `TIMEOUT_CYC`.
  - Cancel and timeout refunds start offering coins 1 cycle after entering PAYOUT.

## Structure
- **Package `seller_pkg`**
  - Coin encoding constants: `COIN_NONE`, `COIN_1`, `COIN_5`, `COIN_10`.
  - Value function `coin_value`.
  - `PRICE_MIN` = 2, `PRICE_MAX` = 10.
  - State enum `txn_state_t`.
- **Sub-module `change_dispenser`**
  - Contents: greedy denomination selector plus handshake hold register.
  - Inputs: `credit`, `active`, `disp_ready`.
  - Outputs: `coin_out_valid`, `coin_out_type`, `dec_amount`.
  - The top-level FSM owns `credit`.

## Test plan
- **Exact payment:** select 7; coins 5 then 1 then 1; confirm -> `ticket_valid` with `ticket_type` = 7; no `coin_out_valid`; back to IDLE; `credit` = 0.
- **Change with stall:** select 3; coin 10 then 10; confirm -> ticket 3, then change 10, 5, 1, 1. Hold `disp_ready` = 0 for 4 cycles mid-sequence -> `coin_out_type` stays stable.
- **Short and cancel:** select 9; coin 5; confirm -> `short_err` pulse; then cancel -> refund of one 5 coin; IDLE.
- **Illegal inputs:** `sel_price` 11 in IDLE -> `sel_err`, state stays IDLE. Coin in IDLE -> `coin_reject`. Coin during PAYOUT -> `coin_reject`, `credit` unchanged.
- **Simultaneous and overflow:** coin 10 + cancel in the same cycle -> refund of 10. Coin 5 + confirm with price 5 and credit 0 -> ticket 5. Credit 250 + coin 10 -> `coin_reject`.
- **Timeout and reset:** `TIMEOUT_CYC` = 8, select 4, coin 1, idle 8 cycles -> refund of one 1 coin. Separately, assert `rst_n` low mid-PAYOUT -> all outputs 0 immediately, state IDLE.
